// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses as short, long, or held with periodic auto-repeat.
// One instance per button; pulse outputs are registered one-cycle strobes, held_out is a level.
`timescale 1ns/1ps
module btn_press_classifier #(
  parameter int unsigned LONG_CYCLES   = 62_500_000,
  parameter int unsigned REPEAT_CYCLES = 12_500_000,
  parameter int unsigned CNT_WIDTH     = 27
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic btn_in,
  input  logic btn_down_in,
  input  logic btn_up_in,
  output logic short_press_out,
  output logic long_press_out,
  output logic repeat_out,
  output logic held_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 btn_in_q;
  logic                 short_d, long_d, repeat_d, held_d;
  logic                 press_c, release_c;

  // Two consecutive low levels recover a release whose up-pulse was lost.
  assign press_c   = btn_down_in;
  assign release_c = btn_up_in | (~btn_in & ~btn_in_q);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state           <= IDLE;
      cnt             <= '0;
      btn_in_q        <= 1'b0;
      short_press_out <= 1'b0;
      long_press_out  <= 1'b0;
      repeat_out      <= 1'b0;
      held_out        <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      btn_in_q        <= btn_in;
      short_press_out <= short_d;
      long_press_out  <= long_d;
      repeat_out      <= repeat_d;
      held_out        <= held_d;
    end
  end

  // Next-state and next-output logic; release always takes priority over terminal counts.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (press_c && !btn_up_in) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (release_c) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      HELD: begin
        if (release_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD);
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier: per-cycle expected outputs queued on drive, checked after the edge.
`timescale 1ns/1ps
module tb_btn_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic down = 1'b0;
  logic up = 1'b0;
  logic short_o, long_o, rep_o, held_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  btn_press_classifier #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_WIDTH    (27)
  ) dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .btn_in         (btn),
    .btn_down_in    (down),
    .btn_up_in      (up),
    .short_press_out(short_o),
    .long_press_out (long_o),
    .repeat_out     (rep_o),
    .held_out       (held_o)
  );

  always #10 clk = ~clk;

  // Drive one cycle of inputs, queue the outputs expected after the sampling edge, then check them.
  // exp bit order: {short, long, repeat, held}
  task automatic step(input logic r, input logic b, input logic d, input logic u,
                      input logic [3:0] exp, input string tag);
    logic [3:0] obs;
    logic [3:0] want;
    rst  = r;
    btn  = b;
    down = d;
    up   = u;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    obs  = {short_o, long_o, rep_o, held_o};
    want = exp_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s obs=%b exp=%b (short,long,repeat,held)", tag, obs, want);
    end
  endtask

  // Press at edge E then k more held cycles; outputs follow from LONG=8, REPEAT=4.
  function automatic logic [3:0] hold_exp(input int k);
    logic l, rp, h;
    l  = (k == 8);
    rp = (k > 8) && (((k - 8) % 4) == 0);
    h  = (k >= 8);
    return {1'b0, l, rp, h};
  endfunction

  initial begin
    // Reset with button level high, then quiet idle
    step(1, 1, 0, 0, 4'b0000, "reset0");
    step(1, 1, 0, 0, 4'b0000, "reset1");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 4'b0000, "post_reset_idle");

    // Short press
    step(0, 1, 1, 0, 4'b0000, "short_down");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'b0000, "short_hold");
    step(0, 0, 0, 1, 4'b1000, "short_pulse");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'b0000, "short_after");

    // Long hold with auto-repeat
    step(0, 1, 1, 0, 4'b0000, "long_down");
    for (int k = 1; k <= 20; k++) step(0, 1, 0, 0, hold_exp(k), "long_hold");
    step(0, 0, 0, 1, 4'b0000, "long_release");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'b0000, "long_after");

    // Release coinciding with long terminal count
    step(0, 1, 1, 0, 4'b0000, "bnd_p_down");
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, 4'b0000, "bnd_p_hold");
    step(0, 0, 0, 1, 4'b1000, "bnd_p_short");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'b0000, "bnd_p_after");

    // Release coinciding with repeat terminal count
    step(0, 1, 1, 0, 4'b0000, "bnd_h_down");
    for (int k = 1; k <= 11; k++) step(0, 1, 0, 0, hold_exp(k), "bnd_h_hold");
    step(0, 0, 0, 1, 4'b0000, "bnd_h_release");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'b0000, "bnd_h_after");

    // Simultaneous down/up in IDLE is a glitch
    step(0, 0, 1, 1, 4'b0000, "glitch");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'b0000, "glitch_after");

    // Lost up-pulse recovered from two low samples
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 4'b0000, "lost_pre");
    step(0, 1, 1, 0, 4'b0000, "lost_down");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 4'b0000, "lost_hold");
    step(0, 0, 0, 0, 4'b0000, "lost_drop1");
    step(0, 0, 0, 0, 4'b1000, "lost_short");
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 4'b0000, "lost_idle");

    // Reset while HELD aborts the hold
    step(0, 1, 1, 0, 4'b0000, "rst_hold_down");
    for (int k = 1; k <= 9; k++) step(0, 1, 0, 0, hold_exp(k), "rst_hold_hold");
    step(1, 1, 0, 0, 4'b0000, "rst_hold_reset");
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 4'b0000, "rst_hold_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
